renkon_net_loader: RTL and testbench

RENKON_NET_LOADER -- requirements
Module: renkon_net_loader

---
 rtl/renkon_pkg.sv | 10 +
 rtl/renkon_net_loader.sv | 122 ++++++++++++
 tb/tb_renkon_net_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/renkon_pkg.sv
// renkon_pkg: shared widths, core geometry and loader FSM states
package renkon_pkg;
    localparam int DWIDTH         = 16;
    localparam int LWIDTH         = 16;
    localparam int RENKON_CORE    = 8;
    localparam int RENKON_CORELOG = 3;
    localparam int RENKON_NETSIZE = 10;

    typedef enum logic [1:0] {IDLE, SETUP, LOAD, DONE} loader_state_e;
endpackage

// File: rtl/renkon_net_loader.sv
// renkon_net_loader: streams conv weights into per-core weight memories, round-robin by output channel
module renkon_net_loader
    import renkon_pkg::*;
(
    input  logic                             clk,
    input  logic                             xrst,
    input  logic                             req,
    input  logic        [RENKON_NETSIZE-1:0] net_base,
    input  logic        [LWIDTH-1:0]         total_out,
    input  logic        [LWIDTH-1:0]         total_in,
    input  logic        [LWIDTH-1:0]         conv_kern,
    input  logic                             bias_en,
    input  logic                             s_valid,
    input  logic signed [DWIDTH-1:0]         s_data,
    output logic                             s_ready,
    output logic        [RENKON_CORELOG-1:0] net_sel,
    output logic                             net_we,
    output logic        [RENKON_NETSIZE-1:0] net_addr,
    output logic signed [DWIDTH-1:0]         net_wdata,
    output logic                             busy,
    output logic                             ack
);
    loader_state_e                state_q, state_d;
    logic [LWIDTH-1:0]            tout_q, tout_d;
    logic [RENKON_NETSIZE-1:0]    wpc_q, wpc_d;
    logic [RENKON_NETSIZE-1:0]    k_q, k_d;
    logic [LWIDTH-1:0]            c_q, c_d;
    logic [RENKON_CORELOG-1:0]    sel_q, sel_d;
    logic [RENKON_NETSIZE-1:0]    chbase_q, chbase_d;
    logic                         we_q, we_d;
    logic [RENKON_CORELOG-1:0]    wsel_q, wsel_d;
    logic [RENKON_NETSIZE-1:0]    waddr_q, waddr_d;
    logic signed [DWIDTH-1:0]     wdata_q, wdata_d;
    logic [RENKON_NETSIZE-1:0]    wpc_calc;
    logic                         word_end, last_ch;

    // weights per channel, computed modulo the address space so wrap matches the memory
    assign wpc_calc = RENKON_NETSIZE'(total_in) * RENKON_NETSIZE'(conv_kern) * RENKON_NETSIZE'(conv_kern)
                    + RENKON_NETSIZE'(bias_en);
    assign word_end = k_q == wpc_q - RENKON_NETSIZE'(1);
    assign last_ch  = c_q == tout_q - LWIDTH'(1);

    assign s_ready   = state_q == LOAD;
    assign busy      = state_q != IDLE;
    assign ack       = state_q == DONE;
    assign net_we    = we_q;
    assign net_sel   = wsel_q;
    assign net_addr  = waddr_q;
    assign net_wdata = wdata_q;

    // next state, channel/word counters and the registered write port
    always_comb begin
        state_d  = state_q;
        tout_d   = tout_q;
        wpc_d    = wpc_q;
        k_d      = k_q;
        c_d      = c_q;
        sel_d    = sel_q;
        chbase_d = chbase_q;
        we_d     = 1'b0;
        wsel_d   = wsel_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE:  state_d = req ? SETUP : IDLE;
            SETUP: begin
                tout_d   = total_out;
                wpc_d    = wpc_calc;
                k_d      = '0;
                c_d      = '0;
                sel_d    = '0;
                chbase_d = net_base;
                state_d  = (total_out == '0 || wpc_calc == '0) ? DONE : LOAD;
            end
            LOAD: if (s_valid) begin
                we_d    = 1'b1;
                wsel_d  = sel_q;
                waddr_d = chbase_q + k_q;
                wdata_d = s_data;
                k_d     = word_end ? '0 : k_q + RENKON_NETSIZE'(1);
                if (word_end) begin
                    c_d   = c_q + LWIDTH'(1);
                    sel_d = sel_q + RENKON_CORELOG'(1);
                    // each core's region advances by one channel once all cores got a channel
                    chbase_d = (sel_q == RENKON_CORELOG'(RENKON_CORE - 1)) ? chbase_q + wpc_q : chbase_q;
                    state_d  = last_ch ? DONE : LOAD;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // all state held in one register bank with asynchronous clear
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q  <= IDLE;
            tout_q   <= '0;
            wpc_q    <= '0;
            k_q      <= '0;
            c_q      <= '0;
            sel_q    <= '0;
            chbase_q <= '0;
            we_q     <= 1'b0;
            wsel_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tout_q   <= tout_d;
            wpc_q    <= wpc_d;
            k_q      <= k_d;
            c_q      <= c_d;
            sel_q    <= sel_d;
            chbase_q <= chbase_d;
            we_q     <= we_d;
            wsel_q   <= wsel_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_renkon_net_loader.sv
// tb_renkon_net_loader: randomized stream checks against a channel/word address model
module tb_renkon_net_loader;
    import renkon_pkg::*;

    logic                             clk = 1'b0;
    logic                             xrst = 1'b0;
    logic                             req = 1'b0;
    logic        [RENKON_NETSIZE-1:0] net_base = '0;
    logic        [LWIDTH-1:0]         total_out = '0, total_in = '0, conv_kern = '0;
    logic                             bias_en = 1'b0, s_valid = 1'b0;
    logic signed [DWIDTH-1:0]         s_data = '0;
    logic                             s_ready, net_we, busy, ack;
    logic        [RENKON_CORELOG-1:0] net_sel;
    logic        [RENKON_NETSIZE-1:0] net_addr;
    logic signed [DWIDTH-1:0]         net_wdata;

    int total = 0, bad = 0, widx = 0;
    bit ack_seen = 0;
    int exp_sel[$], exp_addr[$];
    logic signed [DWIDTH-1:0] exp_data[$];

    renkon_net_loader dut (
        .clk(clk), .xrst(xrst), .req(req), .net_base(net_base), .total_out(total_out),
        .total_in(total_in), .conv_kern(conv_kern), .bias_en(bias_en), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .net_sel(net_sel), .net_we(net_we),
        .net_addr(net_addr), .net_wdata(net_wdata), .busy(busy), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // every write must match the next model entry; ack must land on the last write
    always @(negedge clk) if (xrst) begin
        if (net_we) begin
            if (widx < exp_sel.size()) begin
                chk("wr_sel", 32'(net_sel), exp_sel[widx]);
                chk("wr_addr", 32'(net_addr), exp_addr[widx]);
                chk("wr_data", net_wdata, exp_data[widx]);
            end else chk("extra_write", widx, exp_sel.size());
            widx++;
        end
        if (ack) begin
            chk("ack_with_we", 32'(net_we), 32'(exp_sel.size() != 0));
            chk("ack_count", widx, exp_sel.size());
            ack_seen = 1;
        end
    end

    task automatic run_op(input int tout, input int tin, input int kern, input int bias,
                          input int base, input int duty, input int abort_at);
        int wpc, n, ptr, accepted, cyc;
        bit acc_prev, aborted;
        logic signed [DWIDTH-1:0] stream[$];
        wpc = (tin * kern * kern + bias) % (1 << RENKON_NETSIZE);
        n = (wpc == 0) ? 0 : tout * wpc;
        exp_sel.delete(); exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < n + 4; i++) stream.push_back(DWIDTH'($urandom));
        for (int c = 0; c < tout && wpc != 0; c++)
            for (int k = 0; k < wpc; k++) begin
                exp_sel.push_back(c % RENKON_CORE);
                exp_addr.push_back((base + (c / RENKON_CORE) * wpc + k) % (1 << RENKON_NETSIZE));
                exp_data.push_back(stream[c * wpc + k]);
            end
        widx = 0; ack_seen = 0;
        @(negedge clk);
        total_out = LWIDTH'(tout); total_in = LWIDTH'(tin); conv_kern = LWIDTH'(kern);
        bias_en = bias[0]; net_base = RENKON_NETSIZE'(base); req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ptr = 0; accepted = 0; cyc = 0; acc_prev = 0; aborted = 0;
        while (!ack_seen && cyc < 5000) begin
            if (acc_prev) ptr++;
            if (cyc == 2) begin
                total_out = LWIDTH'($urandom); total_in = LWIDTH'($urandom);
                conv_kern = LWIDTH'($urandom); bias_en = 1'($urandom); net_base = RENKON_NETSIZE'($urandom);
                req = 1'b1;
            end
            if (cyc == 3) req = 1'b0;
            if (abort_at >= 0 && widx >= abort_at) begin
                xrst = 1'b0; s_valid = 1'b0; #1;
                chk("rst_ready", 32'(s_ready), 0); chk("rst_we", 32'(net_we), 0);
                chk("rst_busy", 32'(busy), 0); chk("rst_ack", 32'(ack), 0);
                chk("rst_sel", 32'(net_sel), 0); chk("rst_addr", 32'(net_addr), 0);
                chk("rst_data", net_wdata, 0);
                exp_sel.delete(); exp_addr.delete(); exp_data.delete();
                aborted = 1;
                break;
            end
            s_valid = (ptr < stream.size()) && ($urandom_range(99) < duty);
            s_data = (ptr < stream.size()) ? stream[ptr] : '0;
            acc_prev = s_valid && s_ready;
            accepted += int'(acc_prev);
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0; req = 1'b0;
        if (aborted) begin
            repeat (3) @(negedge clk);
            xrst = 1'b1;
            repeat (3) @(negedge clk);
        end else begin
            chk("ack_seen", 32'(ack_seen), 1);
            chk("writes", widx, n);
            chk("accepted", accepted, n);
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(s_ready), 0); chk("reset_we", 32'(net_we), 0);
        chk("reset_busy", 32'(busy), 0); chk("reset_ack", 32'(ack), 0);
        chk("reset_addr", 32'(net_addr), 0); chk("reset_data", net_wdata, 0);
        xrst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8, 1, 3, 1, 0, 100, -1);
        chk("pin_n80", exp_addr.size(), 80);
        chk("pin_last_sel", exp_sel[79], 7);
        chk("pin_last_addr", exp_addr[79], 9);

        run_op(10, 1, 3, 1, 100, 100, -1);
        chk("pin_c8_sel", exp_sel[80], 0);
        chk("pin_c8_addr", exp_addr[80], 110);
        chk("pin_c9_addr", exp_addr[99], 119);
        chk("pin_c7_addr", exp_addr[79], 109);

        exp_sel.delete(); exp_addr.delete(); exp_data.delete();
        widx = 0; ack_seen = 0;
        total_out = '0; total_in = 16'd2; conv_kern = 16'd3; bias_en = 1'b1;
        req = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("z_setup_busy", 32'(busy), 1); chk("z_setup_ack", 32'(ack), 0); chk("z_setup_ready", 32'(s_ready), 0);
        @(negedge clk);
        chk("z_done_ack", 32'(ack), 1); chk("z_done_ready", 32'(s_ready), 0);
        @(negedge clk);
        chk("z_idle_ack", 32'(ack), 0); chk("z_idle_busy", 32'(busy), 0); chk("z_writes", widx, 0);
        s_valid = 1'b0;

        run_op(8, 1, 3, 1, 0, 50, -1);

        run_op(9, 1, 2, 0, (1 << RENKON_NETSIZE) - 2, 100, -1);
        chk("pin_wrap0", exp_addr[2], 0);
        chk("pin_wrap1", exp_addr[3], 1);
        chk("pin_wrap_c8", exp_addr[32], 2);

        run_op(8, 1, 3, 1, 50, 100, 5);
        run_op(8, 1, 3, 1, 50, 70, -1);

        run_op(5, 0, 3, 0, 7, 100, -1);
        for (int i = 0; i < 6; i++)
            run_op($urandom_range(1, 20), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(30, 100), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
